sc_preamble_inserter: RTL and testbench
=======================================

// Module: sc_preamble_inserter
// PURPOSE
//   Transmit-side counterpart of the Schmidl-Cox burst detector. Prepends a
//   periodic training preamble (NUM_REPS copies of a programmable SEQ_LEN-sample
//   sequence) to every AXI-stream packet. The receive correlator then sees a
//   metric plateau of (NUM_REPS-1)*SEQ_LEN samples. Sits in the TX chain
//   between the packet source and the DUC.
// PARAMETERS
//   WIDTH      32   sample width, {I[31:16],Q[15:0]}
//   SEQ_LEN    16   samples per short sequence; power of 2, 2..256
//   NUM_REPS   10   sequence repetitions per preamble, 1..255
//   GUARD_LEN  16   zero samples between preamble and payload (GUARD_EN only), 1..255
//   SR_BASE    0    settings-bus base address
// PORTS
//   clk        in   1      clock
//   reset      in   1      reset
//   clear      in   1      sync soft clear: state/counters only, config kept
//   set_stb    in   1      settings write strobe
//   set_addr   in   8      settings address
//   set_data   in   32     settings data
//   i_tdata    in   WIDTH  payload samples
//   i_tlast    in   1      end of payload packet
//   i_tvalid   in   1      input valid
//   i_tready   out  1      input ready
//   o_tdata    out  WIDTH  preamble+payload samples
//   o_tlast    out  1      end of output packet (= payload i_tlast)
//   o_tvalid   out  1      output valid
//   o_tready   in   1      output ready
// BEHAVIOUR
//   - reset: synchronous, active-high. State IDLE, counters 0, table all 0,
//     enable 0, tbl_idx 0. Outputs: o_tvalid=0, o_tlast=0, o_tdata=0, i_tready=0.
//   - clear: same as reset, except table, tbl_idx and enable are kept.
//     reset/clear mid-packet: o_tvalid drops the next cycle; partial packet abandoned.
//   - Settings registers:
//       SR_BASE+0  tbl_idx  <= set_data[log2(SEQ_LEN)-1:0] (upper bits ignored)
//       SR_BASE+1  table[tbl_idx] <= set_data; tbl_idx++ (wraps to 0)
//       SR_BASE+2  enable   <= set_data[0]
//   - Writes to SR_BASE+0/+1 while state!=IDLE are dropped, so o_tdata stays
//     stable. Enable writes are accepted any time; enable is sampled only on
//     leaving IDLE.
//   - FSM:
//       IDLE: o_tvalid=0, i_tready=0. When i_tvalid=1: go to PREAMBLE if
//         enable=1, else PAYLOAD. Transition is at the next edge.
//       PREAMBLE: o_tdata=table[seq_idx], o_tvalid=1, o_tlast=0, i_tready=0.
//         On each o_tvalid&o_tready: seq_idx++. When seq_idx==SEQ_LEN-1,
//         seq_idx wraps to 0 and rep_cnt++. Accepting seq_idx==SEQ_LEN-1 with
//         rep_cnt==NUM_REPS-1 goes to GUARD (GUARD_EN) or PAYLOAD; counters clear.
//       GUARD: o_tdata=0, o_tvalid=1. After GUARD_LEN accepted samples -> PAYLOAD.
//       PAYLOAD: pass-through. o_tdata=i_tdata, o_tlast=i_tlast,
//         o_tvalid=i_tvalid, i_tready=o_tready. A handshake with i_tlast=1
//         goes to IDLE.
//   - Latency:
//       * First preamble sample is valid 1 cycle after i_tvalid is seen in IDLE.
//       * Payload path is combinational (0 cycles).
//       * Back-to-back packets have one IDLE bubble between them.
//   - AXI: once o_tvalid is asserted in PREAMBLE/GUARD, o_tvalid and o_tdata
//     hold until accepted. A 1-sample payload (i_tlast on first beat) is legal.
//   - Output length per packet = NUM_REPS*SEQ_LEN [+GUARD_LEN] + payload length.
// CONFIGURATION
//   GUARD_EN defined:   GUARD state compiled in; GUARD_LEN zeros are emitted
//                       after the preamble.
//   GUARD_EN undefined: no GUARD state, guard counter or logic; GUARD_LEN is
//                       ignored; PREAMBLE goes straight to PAYLOAD.
// TESTING
//   1 Load table k=0..15 with 0x00010000*k, enable=1. Send a 4-sample payload
//     (A,B,C,D), o_tready=1 -> exactly 160 preamble samples cycling 0x0..0xF0000
//     ten times, then A..D with o_tlast only on D; 164 beats total (180 with
//     GUARD_EN and 16 zeros).
//   2 Same as 1 with o_tready toggled pseudo-randomly -> identical sample
//     sequence; o_tdata never changes while o_tvalid=1 and o_tready=0.
//   3 enable=0, 3-sample packet -> output is the 3 samples unchanged, zero
//     preamble, i_tready==o_tready throughout PAYLOAD.
//   4 Write SR_BASE+1=0xDEAD0000 during PREAMBLE -> write ignored; table and
//     tbl_idx unchanged, verified by readback through the next packet's preamble.
//   5 Assert clear at preamble beat 50 -> o_tvalid=0 next cycle. A new packet
//     gets a full 160-sample preamble with the table intact.
//   6 Two back-to-back 1-sample packets -> two complete preambles, each
//     payload beat has o_tlast=1, one idle cycle between packets.

Source files
------------

// File: rtl/sc_preamble_inserter.sv
// Prepends NUM_REPS copies of a programmable SEQ_LEN-sample training sequence to each AXI-stream packet.
// Define GUARD_EN to emit GUARD_LEN zero samples between the preamble and the payload.
module sc_preamble_inserter #(
    parameter int WIDTH     = 32,
    parameter int SEQ_LEN   = 16,
    parameter int NUM_REPS  = 10,
    parameter int GUARD_LEN = 16,
    parameter int SR_BASE   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             set_stb,
    input  logic [7:0]       set_addr,
    input  logic [31:0]      set_data,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_tlast,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             o_tready,
    output logic [1:0]       dbg_state_o
);

    localparam int IDX_W = $clog2(SEQ_LEN);
    localparam logic [7:0] ADDR_IDX  = 8'(SR_BASE);
    localparam logic [7:0] ADDR_DATA = 8'(SR_BASE + 1);
    localparam logic [7:0] ADDR_EN   = 8'(SR_BASE + 2);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PREAMBLE = 2'd1,
        S_PAYLOAD  = 2'd2
`ifdef GUARD_EN
        , S_GUARD  = 2'd3
`endif
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     seq_idx_q, seq_idx_d;
    logic [7:0]           rep_cnt_q, rep_cnt_d;
`ifdef GUARD_EN
    logic [7:0]           guard_cnt_q, guard_cnt_d;
`endif
    logic [IDX_W-1:0]     tbl_idx_q;
    logic                 enable_q;
    logic [WIDTH-1:0]     tbl_q [SEQ_LEN];

    assign dbg_state_o = state_q;

    // Table writes are only taken in IDLE so o_tdata never shifts under a stalled preamble beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            tbl_idx_q <= '0;
            enable_q  <= 1'b0;
            for (int i = 0; i < SEQ_LEN; i++) tbl_q[i] <= '0;
        end else begin
            if (set_stb && set_addr == ADDR_EN) enable_q <= set_data[0];
            if (set_stb && state_q == S_IDLE) begin
                if (set_addr == ADDR_IDX) tbl_idx_q <= set_data[IDX_W-1:0];
                if (set_addr == ADDR_DATA) begin
                    tbl_q[tbl_idx_q] <= WIDTH'(set_data);
                    tbl_idx_q        <= tbl_idx_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_q     <= S_IDLE;
            seq_idx_q   <= '0;
            rep_cnt_q   <= '0;
`ifdef GUARD_EN
            guard_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            seq_idx_q   <= seq_idx_d;
            rep_cnt_q   <= rep_cnt_d;
`ifdef GUARD_EN
            guard_cnt_q <= guard_cnt_d;
`endif
        end
    end

    // Handshake: a beat moves on a rising edge where valid and ready are both high;
    // the generated beats hold o_tvalid/o_tdata until taken, payload is a wire path.
    always_comb begin
        state_d     = state_q;
        seq_idx_d   = seq_idx_q;
        rep_cnt_d   = rep_cnt_q;
`ifdef GUARD_EN
        guard_cnt_d = guard_cnt_q;
`endif
        o_tdata     = '0;
        o_tlast     = 1'b0;
        o_tvalid    = 1'b0;
        i_tready    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_tvalid) state_d = enable_q ? S_PREAMBLE : S_PAYLOAD;
            end
            S_PREAMBLE: begin
                o_tdata  = tbl_q[seq_idx_q];
                o_tvalid = 1'b1;
                if (o_tready) begin
                    seq_idx_d = seq_idx_q + 1'b1;
                    if (seq_idx_q == IDX_W'(SEQ_LEN - 1)) begin
                        if (rep_cnt_q == 8'(NUM_REPS - 1)) begin
                            rep_cnt_d = '0;
`ifdef GUARD_EN
                            state_d   = S_GUARD;
`else
                            state_d   = S_PAYLOAD;
`endif
                        end else begin
                            rep_cnt_d = rep_cnt_q + 8'd1;
                        end
                    end
                end
            end
`ifdef GUARD_EN
            S_GUARD: begin
                o_tvalid = 1'b1;
                if (o_tready) begin
                    if (guard_cnt_q == 8'(GUARD_LEN - 1)) begin
                        guard_cnt_d = '0;
                        state_d     = S_PAYLOAD;
                    end else begin
                        guard_cnt_d = guard_cnt_q + 8'd1;
                    end
                end
            end
`endif
            S_PAYLOAD: begin
                o_tdata  = i_tdata;
                o_tlast  = i_tlast;
                o_tvalid = i_tvalid;
                i_tready = o_tready;
                if (i_tvalid && o_tready && i_tlast) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_sc_preamble_inserter.sv
// Directed bench for sc_preamble_inserter; honours GUARD_EN by expecting 16 extra zero beats.
module tb_sc_preamble_inserter;

`ifdef GUARD_EN
    localparam int GL = 16;
`else
    localparam int GL = 0;
`endif
    localparam int PRE = 160;

    logic        clk = 1'b0;
    logic        reset, clear, set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data, i_tdata, o_tdata;
    logic        i_tlast, i_tvalid, i_tready;
    logic        o_tlast, o_tvalid, o_tready;
    logic [1:0]  dbg_state_o;

    int compares = 0;
    int errors   = 0;
    int cyc      = 0;
    logic [32:0] cap_q[$];
    int          cap_cyc[$];
    logic [32:0] exp_q[$];
    logic [31:0] tbl_m [16];
    bit   rand_ready = 0, stab_en = 0, pass_en = 0;
    int   stab_err = 0, pass_err = 0;
    logic prev_stall = 1'b0;
    logic [31:0] prev_data = '0;

    sc_preamble_inserter dut (
        .clk(clk), .reset(reset), .clear(clear),
        .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
        .dbg_state_o(dbg_state_o)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // output monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (stab_en && prev_stall && (o_tvalid !== 1'b1 || o_tdata !== prev_data)) stab_err++;
        prev_stall = o_tvalid && !o_tready;
        prev_data  = o_tdata;
        if (pass_en && o_tvalid === 1'b1 && (i_tready !== o_tready || o_tdata !== i_tdata)) pass_err++;
        if (o_tvalid === 1'b1 && o_tready === 1'b1) begin
            cap_q.push_back({o_tlast, o_tdata});
            cap_cyc.push_back(cyc);
        end
    end

    // pseudo-random backpressure
    initial forever begin
        @(posedge clk); #1;
        if (rand_ready) o_tready = 1'($urandom_range(0, 1));
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic sr_write(input logic [7:0] a, input logic [31:0] d);
        set_stb = 1'b1; set_addr = a; set_data = d;
        tick(1);
        set_stb = 1'b0;
    endtask

    task automatic send_pkt(input int n, input logic [31:0] base);
        for (int b = 0; b < n; b++) begin
            int wait_c;
            wait_c   = 0;
            i_tdata  = base + 32'(b);
            i_tlast  = (b == n - 1);
            i_tvalid = 1'b1;
            while (1) begin
                @(negedge clk);
                if (i_tready === 1'b1) break;
                wait_c++;
                if (wait_c > 3000) begin
                    $display("FAIL send_timeout: beat %0d not accepted after %0d cycles, needed <= 3000", b, wait_c);
                    compares++; errors++;
                    i_tvalid = 1'b0; i_tlast = 1'b0;
                    @(posedge clk); #1;
                    return;
                end
            end
            @(posedge clk); #1;
        end
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
    endtask

    // appends one packet's expected beats {tlast, tdata}
    task automatic build_exp(input int n, input logic [31:0] base);
        for (int r = 0; r < 10; r++)
            for (int k = 0; k < 16; k++) exp_q.push_back({1'b0, tbl_m[k]});
        for (int g = 0; g < GL; g++) exp_q.push_back(33'd0);
        for (int b = 0; b < n; b++) exp_q.push_back({(b == n - 1), base + 32'(b)});
    endtask

    task automatic test_reset();
        reset = 1'b1; clear = 1'b0; set_stb = 1'b0; set_addr = '0; set_data = '0;
        i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b0; o_tready = 1'b1;
        tick(3);
        reset = 1'b0;
        compares++; if (o_tvalid !== 1'b0) begin $display("FAIL rst_tvalid: got %b want 0", o_tvalid); errors++; end
        compares++; if (o_tlast !== 1'b0) begin $display("FAIL rst_tlast: got %b want 0", o_tlast); errors++; end
        compares++; if (o_tdata !== 32'h0) begin $display("FAIL rst_tdata: got %h want 0", o_tdata); errors++; end
        compares++; if (i_tready !== 1'b0) begin $display("FAIL rst_tready: got %b want 0", i_tready); errors++; end
        compares++; if (dbg_state_o !== 2'd0) begin $display("FAIL rst_state: got %0d want 0", dbg_state_o); errors++; end
    endtask

    task automatic test_table_reset();
        int first;
        for (int k = 0; k < 16; k++) tbl_m[k] = 32'h0;
        sr_write(8'd2, 32'h1);
        cap_q.delete(); cap_cyc.delete(); exp_q.delete();
        send_pkt(1, 32'hAAAA_0001);
        tick(3);
        build_exp(1, 32'hAAAA_0001);
        compares++;
        if (cap_q.size() != exp_q.size()) begin $display("FAIL tblrst_len: got %0d beats want %0d", cap_q.size(), exp_q.size()); errors++; end
        first = -1;
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) if (cap_q[i] !== exp_q[i]) begin first = i; break; end
        compares++;
        if (first >= 0) begin $display("FAIL tblrst_data: beat %0d got %h want %h", first, cap_q[first], exp_q[first]); errors++; end
    endtask

    task automatic test_basic();
        int first;
        for (int k = 0; k < 16; k++) begin
            tbl_m[k] = 32'h0001_0000 * k;
            sr_write(8'd1, tbl_m[k]);
        end
        cap_q.delete(); cap_cyc.delete(); exp_q.delete();
        send_pkt(4, 32'h1111_0001);
        tick(3);
        build_exp(4, 32'h1111_0001);
        compares++;
        if (cap_q.size() != PRE + GL + 4) begin $display("FAIL basic_len: got %0d beats want %0d", cap_q.size(), PRE + GL + 4); errors++; end
        first = -1;
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) if (cap_q[i] !== exp_q[i]) begin first = i; break; end
        compares++;
        if (first >= 0) begin $display("FAIL basic_data: beat %0d got %h want %h", first, cap_q[first], exp_q[first]); errors++; end
    endtask

    task automatic test_backpressure();
        int first;
        cap_q.delete(); cap_cyc.delete(); exp_q.delete();
        stab_err = 0; stab_en = 1; rand_ready = 1;
        send_pkt(4, 32'h2222_0001);
        rand_ready = 0;
        tick(1);
        o_tready = 1'b1;
        tick(3);
        stab_en = 0;
        build_exp(4, 32'h2222_0001);
        compares++;
        if (cap_q.size() != exp_q.size()) begin $display("FAIL bp_len: got %0d beats want %0d", cap_q.size(), exp_q.size()); errors++; end
        first = -1;
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) if (cap_q[i] !== exp_q[i]) begin first = i; break; end
        compares++;
        if (first >= 0) begin $display("FAIL bp_data: beat %0d got %h want %h", first, cap_q[first], exp_q[first]); errors++; end
        compares++;
        if (stab_err != 0) begin $display("FAIL bp_stable: got %0d unstable stalls want 0", stab_err); errors++; end
    endtask

    task automatic test_bypass();
        int first;
        sr_write(8'd2, 32'h0);
        cap_q.delete(); cap_cyc.delete(); exp_q.delete();
        pass_err = 0; pass_en = 1; rand_ready = 1;
        send_pkt(3, 32'h3333_0001);
        rand_ready = 0;
        tick(1);
        o_tready = 1'b1;
        tick(2);
        pass_en = 0;
        for (int b = 0; b < 3; b++) exp_q.push_back({(b == 2), 32'h3333_0001 + 32'(b)});
        compares++;
        if (cap_q.size() != 3) begin $display("FAIL byp_len: got %0d beats want 3", cap_q.size()); errors++; end
        first = -1;
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) if (cap_q[i] !== exp_q[i]) begin first = i; break; end
        compares++;
        if (first >= 0) begin $display("FAIL byp_data: beat %0d got %h want %h", first, cap_q[first], exp_q[first]); errors++; end
        compares++;
        if (pass_err != 0) begin $display("FAIL byp_ready: got %0d ready/data diffs want 0", pass_err); errors++; end
        sr_write(8'd2, 32'h1);
    endtask

    task automatic test_cfg_lock();
        int first;
        cap_q.delete(); cap_cyc.delete(); exp_q.delete();
        fork
            send_pkt(2, 32'h4444_0001);
            begin tick(20); sr_write(8'd1, 32'hDEAD_0000); end
        join
        tick(3);
        build_exp(2, 32'h4444_0001);
        // tbl_idx wrapped to 0 after the 16 loads, so this lands in entry 0 only if the locked write was dropped
        sr_write(8'd1, 32'h1234_5678);
        tbl_m[0] = 32'h1234_5678;
        send_pkt(1, 32'h4444_0101);
        tick(3);
        build_exp(1, 32'h4444_0101);
        compares++;
        if (cap_q.size() != exp_q.size()) begin $display("FAIL lock_len: got %0d beats want %0d", cap_q.size(), exp_q.size()); errors++; end
        first = -1;
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) if (cap_q[i] !== exp_q[i]) begin first = i; break; end
        compares++;
        if (first >= 0) begin $display("FAIL lock_data: beat %0d got %h want %h", first, cap_q[first], exp_q[first]); errors++; end
        sr_write(8'd0, 32'hFFFF_FF00);
        sr_write(8'd1, 32'h0);
        tbl_m[0] = 32'h0;
    endtask

    task automatic test_clear();
        int first;
        int w;
        cap_q.delete(); cap_cyc.delete(); exp_q.delete();
        fork
            send_pkt(2, 32'h5555_0001);
            begin
                w = 0;
                while (cap_q.size() < 50 && w < 3000) begin tick(1); w++; end
                compares++;
                if (dbg_state_o !== 2'd1) begin $display("FAIL clr_midpre: state %0d want 1 at beat 50", dbg_state_o); errors++; end
                clear = 1'b1;
                tick(1);
                clear = 1'b0;
                compares++;
                if (o_tvalid !== 1'b0) begin $display("FAIL clr_tvalid: got %b want 0", o_tvalid); errors++; end
                cap_q.delete(); cap_cyc.delete();
            end
        join
        tick(3);
        build_exp(2, 32'h5555_0001);
        compares++;
        if (cap_q.size() != exp_q.size()) begin $display("FAIL clr_len: got %0d beats want %0d", cap_q.size(), exp_q.size()); errors++; end
        first = -1;
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) if (cap_q[i] !== exp_q[i]) begin first = i; break; end
        compares++;
        if (first >= 0) begin $display("FAIL clr_data: beat %0d got %h want %h", first, cap_q[first], exp_q[first]); errors++; end
    endtask

    task automatic test_back_to_back();
        int first;
        int gap;
        cap_q.delete(); cap_cyc.delete(); exp_q.delete();
        send_pkt(1, 32'h6666_0001);
        send_pkt(1, 32'h6666_0002);
        tick(3);
        build_exp(1, 32'h6666_0001);
        build_exp(1, 32'h6666_0002);
        compares++;
        if (cap_q.size() != 2 * (PRE + GL + 1)) begin $display("FAIL b2b_len: got %0d beats want %0d", cap_q.size(), 2 * (PRE + GL + 1)); errors++; end
        first = -1;
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) if (cap_q[i] !== exp_q[i]) begin first = i; break; end
        compares++;
        if (first >= 0) begin $display("FAIL b2b_data: beat %0d got %h want %h", first, cap_q[first], exp_q[first]); errors++; end
        gap = (cap_cyc.size() > PRE + GL + 1) ? cap_cyc[PRE + GL + 1] - cap_cyc[PRE + GL] : -1;
        compares++;
        if (gap != 2) begin $display("FAIL b2b_gap: got %0d cycles between packets want 2", gap); errors++; end
    endtask

    initial begin
        test_reset();
        test_table_reset();
        test_basic();
        test_backpressure();
        test_bypass();
        test_cfg_lock();
        test_clear();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
        $finish;
    end

endmodule
